// File: rtl/memory_writeback.sv
// rtl/memory_writeback.sv - memory access and register-file write-back stage
// Purpose: consumes execute-stage results, runs loads/stores on a req/ack
//          data-memory bus and drives the register-file write port.
// Ports:   ms_clk/ms_rst          clock, async active-low reset
//          ms_i_*                 execute result (ce, flush, opcode, funct3, alu, rs2, rd, we_reg)
//          ms_o_stall             upstream hold while an access is outstanding
//          ms_o_mem_*/ms_i_mem_*  data-memory request/acknowledge bus
//          ms_o_we/addr_rd/data_rd register-file write port
//          ms_o_misaligned        misaligned-access pulse
// Config:  MISALIGN_CHECK_EN enables misaligned-access detection.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module memory_writeback #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic                     ms_clk,
    input  logic                     ms_rst,
    input  logic                     ms_i_ce,
    input  logic                     ms_i_flush,
    input  logic [`OPCODE_WIDTH-1:0] ms_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]   ms_i_funct3,
    input  logic [DWIDTH-1:0]        ms_i_alu_value,
    input  logic [DWIDTH-1:0]        ms_i_data_rs2,
    input  logic [AWIDTH-1:0]        ms_i_addr_rd,
    input  logic                     ms_i_we_reg,
    output logic                     ms_o_stall,
    output logic                     ms_o_mem_req,
    output logic                     ms_o_mem_we,
    output logic [DWIDTH-1:0]        ms_o_mem_addr,
    output logic [DWIDTH-1:0]        ms_o_mem_wdata,
    output logic [3:0]               ms_o_mem_wstrb,
    input  logic                     ms_i_mem_ack,
    input  logic [DWIDTH-1:0]        ms_i_mem_rdata,
    output logic                     ms_o_we,
    output logic [AWIDTH-1:0]        ms_o_addr_rd,
    output logic [DWIDTH-1:0]        ms_o_data_rd,
    output logic                     ms_o_misaligned
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic                   accept, is_load, is_store, is_mem;
    logic                   size_byte, size_half, misaligned_in;
    logic [1:0]             lane;
    logic [DWIDTH-1:0]      wdata_nxt;
    logic [3:0]             wstrb_nxt;
    logic [FUNCT_WIDTH-1:0] funct3_q;
    logic [1:0]             lane_q;
    logic [AWIDTH-1:0]      rd_q;
    logic                   wb_en_q;
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;
    logic [DWIDTH-1:0]      load_data;
    logic                   unused_opcode_bits;

    assign unused_opcode_bits = ^ms_i_opcode;

    assign accept    = (state == IDLE) && ms_i_ce && !ms_i_flush;
    assign is_store  = ms_i_opcode[`STORE];
    assign is_load   = ms_i_opcode[`LOAD] && !is_store;
    assign is_mem    = is_load || is_store;
    assign lane      = ms_i_alu_value[1:0];
    assign size_byte = (ms_i_funct3[1:0] == 2'b00);
    assign size_half = (ms_i_funct3[1:0] == 2'b01);

`ifdef MISALIGN_CHECK_EN
    // Anything that is neither byte nor half is treated as a word access.
    assign misaligned_in = is_mem && ((size_half && lane[0]) ||
                                      (!size_byte && !size_half && (lane != 2'b00)));
`else
    assign misaligned_in = 1'b0;
`endif

    assign ms_o_stall   = (state == ACCESS);
    assign ms_o_mem_req = (state == ACCESS);

    always_comb begin
        wdata_nxt = ms_i_data_rs2;
        wstrb_nxt = 4'b1111;
        if (size_byte) begin
            wdata_nxt = {4{ms_i_data_rs2[7:0]}};
            wstrb_nxt = 4'b0001 << lane;
        end else if (size_half) begin
            wdata_nxt = {2{ms_i_data_rs2[15:0]}};
            wstrb_nxt = lane[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = ms_i_mem_rdata[7:0];
            2'd1:    byte_sel = ms_i_mem_rdata[15:8];
            2'd2:    byte_sel = ms_i_mem_rdata[23:16];
            default: byte_sel = ms_i_mem_rdata[31:24];
        endcase
        half_sel  = lane_q[1] ? ms_i_mem_rdata[31:16] : ms_i_mem_rdata[15:0];
        load_data = ms_i_mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            load_data = {{24{!funct3_q[2] && byte_sel[7]}}, byte_sel};
        end else if (funct3_q[1:0] == 2'b01) begin
            load_data = {{16{!funct3_q[2] && half_sel[15]}}, half_sel};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_mem && !misaligned_in) state_nxt = ACCESS;
            ACCESS:  if (ms_i_mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ms_clk or negedge ms_rst) begin
        if (!ms_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge ms_clk or negedge ms_rst) begin
        if (!ms_rst) begin
            ms_o_mem_we     <= 1'b0;
            ms_o_mem_addr   <= '0;
            ms_o_mem_wdata  <= '0;
            ms_o_mem_wstrb  <= 4'b0000;
            ms_o_we         <= 1'b0;
            ms_o_addr_rd    <= '0;
            ms_o_data_rd    <= '0;
            ms_o_misaligned <= 1'b0;
            funct3_q        <= '0;
            lane_q          <= 2'b00;
            rd_q            <= '0;
            wb_en_q         <= 1'b0;
        end else begin
            ms_o_we         <= 1'b0;
            ms_o_misaligned <= 1'b0;
            if (accept) begin
                if (!is_mem) begin
                    ms_o_we      <= ms_i_we_reg && (ms_i_addr_rd != '0);
                    ms_o_addr_rd <= ms_i_addr_rd;
                    ms_o_data_rd <= ms_i_alu_value;
                end else if (misaligned_in) begin
                    ms_o_misaligned <= 1'b1;
                end else begin
                    ms_o_mem_we    <= is_store;
                    ms_o_mem_addr  <= {ms_i_alu_value[DWIDTH-1:2], 2'b00};
                    ms_o_mem_wdata <= is_store ? wdata_nxt : '0;
                    ms_o_mem_wstrb <= is_store ? wstrb_nxt : 4'b0000;
                    funct3_q       <= ms_i_funct3;
                    lane_q         <= lane;
                    rd_q           <= ms_i_addr_rd;
                    wb_en_q        <= is_load && ms_i_we_reg && (ms_i_addr_rd != '0);
                end
            end
            if (state == ACCESS) begin
                // A flush only cancels the write-back; the bus transfer runs to completion.
                if (ms_i_flush) wb_en_q <= 1'b0;
                if (ms_i_mem_ack && wb_en_q && !ms_i_flush) begin
                    ms_o_we      <= 1'b1;
                    ms_o_addr_rd <= rd_q;
                    ms_o_data_rd <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_writeback.sv
// tb/tb_memory_writeback.sv - scoreboard testbench for memory_writeback
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module tb_memory_writeback;

    logic                     ms_clk = 1'b0;
    logic                     ms_rst = 1'b0;
    logic                     ms_i_ce = 1'b0;
    logic                     ms_i_flush = 1'b0;
    logic [`OPCODE_WIDTH-1:0] ms_i_opcode = '0;
    logic [2:0]               ms_i_funct3 = '0;
    logic [31:0]              ms_i_alu_value = '0;
    logic [31:0]              ms_i_data_rs2 = '0;
    logic [4:0]               ms_i_addr_rd = '0;
    logic                     ms_i_we_reg = 1'b0;
    logic                     ms_o_stall, ms_o_mem_req, ms_o_mem_we;
    logic [31:0]              ms_o_mem_addr, ms_o_mem_wdata;
    logic [3:0]               ms_o_mem_wstrb;
    logic                     ms_i_mem_ack = 1'b0;
    logic [31:0]              ms_i_mem_rdata = '0;
    logic                     ms_o_we;
    logic [4:0]               ms_o_addr_rd;
    logic [31:0]              ms_o_data_rd;
    logic                     ms_o_misaligned;

    memory_writeback dut (
        .ms_clk(ms_clk), .ms_rst(ms_rst), .ms_i_ce(ms_i_ce), .ms_i_flush(ms_i_flush),
        .ms_i_opcode(ms_i_opcode), .ms_i_funct3(ms_i_funct3),
        .ms_i_alu_value(ms_i_alu_value), .ms_i_data_rs2(ms_i_data_rs2),
        .ms_i_addr_rd(ms_i_addr_rd), .ms_i_we_reg(ms_i_we_reg),
        .ms_o_stall(ms_o_stall), .ms_o_mem_req(ms_o_mem_req), .ms_o_mem_we(ms_o_mem_we),
        .ms_o_mem_addr(ms_o_mem_addr), .ms_o_mem_wdata(ms_o_mem_wdata),
        .ms_o_mem_wstrb(ms_o_mem_wstrb), .ms_i_mem_ack(ms_i_mem_ack),
        .ms_i_mem_rdata(ms_i_mem_rdata), .ms_o_we(ms_o_we), .ms_o_addr_rd(ms_o_addr_rd),
        .ms_o_data_rd(ms_o_data_rd), .ms_o_misaligned(ms_o_misaligned)
    );

    always #5 ms_clk = ~ms_clk;

    int          errors = 0;
    int          checks = 0;
    logic [36:0] sb_q[$];
    logic [36:0] sb_exp;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we, stable_ok;
    int          req_cycles, stall_cycles;

    logic [`OPCODE_WIDTH-1:0] op_add, op_load, op_store;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write-back monitor: every register write must match the oldest expectation.
    always @(negedge ms_clk) begin
        if (ms_rst && ms_o_we) begin
            if (sb_q.size() == 0) begin
                check_val("wb_unexpected", 32'd1, 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check_val("wb_addr", {27'd0, ms_o_addr_rd}, {27'd0, sb_exp[36:32]});
                check_val("wb_data", ms_o_data_rd, sb_exp[31:0]);
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] ln,
                                               input logic [31:0] w);
        logic [31:0] s;
        case (f3)
            3'b000: begin s = w >> (int'(ln) * 8); return {{24{s[7]}}, s[7:0]}; end
            3'b100: begin s = w >> (int'(ln) * 8); return {24'd0, s[7:0]}; end
            3'b001: begin s = w >> (ln[1] ? 16 : 0); return {{16{s[15]}}, s[15:0]}; end
            3'b101: begin s = w >> (ln[1] ? 16 : 0); return {16'd0, s[15:0]}; end
            default: return w;
        endcase
    endfunction

    task automatic issue(input logic [`OPCODE_WIDTH-1:0] opc, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic wer);
        @(negedge ms_clk);
        ms_i_opcode = opc; ms_i_funct3 = f3; ms_i_alu_value = alu;
        ms_i_data_rs2 = rs2; ms_i_addr_rd = rd; ms_i_we_reg = wer; ms_i_ce = 1'b1;
        @(posedge ms_clk);
        #1 ms_i_ce = 1'b0;
    endtask

    // Memory responder: ack in the (wait_n+1)-th access cycle, optional flush at cycle flush_at.
    task automatic serve(input int wait_n, input logic [31:0] rdata, input int flush_at);
        req_cycles = 0; stall_cycles = 0; stable_ok = 1'b1;
        for (int k = 0; k <= wait_n; k++) begin
            @(negedge ms_clk);
            if (k == 0) begin
                cap_addr = ms_o_mem_addr; cap_wdata = ms_o_mem_wdata;
                cap_wstrb = ms_o_mem_wstrb; cap_we = ms_o_mem_we;
            end else if (ms_o_mem_addr !== cap_addr || ms_o_mem_wdata !== cap_wdata ||
                         ms_o_mem_wstrb !== cap_wstrb || ms_o_mem_we !== cap_we) begin
                stable_ok = 1'b0;
            end
            if (ms_o_mem_req) req_cycles++;
            if (ms_o_stall) stall_cycles++;
            if (k == flush_at) ms_i_flush = 1'b1;
            if (k == wait_n) begin ms_i_mem_ack = 1'b1; ms_i_mem_rdata = rdata; end
        end
        @(posedge ms_clk);
        #1;
        ms_i_mem_ack = 1'b0; ms_i_flush = 1'b0; ms_i_mem_rdata = '0;
    endtask

    task automatic after_access(input logic exp_we);
        @(negedge ms_clk);
        check_val("post_we", {31'd0, ms_o_we}, {31'd0, exp_we});
        check_val("post_stall", {31'd0, ms_o_stall}, 32'd0);
        check_val("post_req", {31'd0, ms_o_mem_req}, 32'd0);
        @(negedge ms_clk);
        check_val("post_we_drop", {31'd0, ms_o_we}, 32'd0);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [2:0]  f3;
        logic [1:0]  ln;
        op_add   = '0; op_add[0] = 1'b1;
        op_load  = '0; op_load[`LOAD] = 1'b1;
        op_store = '0; op_store[`STORE] = 1'b1;

        repeat (2) @(negedge ms_clk);
        check_val("rst_stall", {31'd0, ms_o_stall}, 32'd0);
        check_val("rst_req", {31'd0, ms_o_mem_req}, 32'd0);
        check_val("rst_we", {31'd0, ms_o_we}, 32'd0);
        check_val("rst_addr", ms_o_mem_addr, 32'd0);
        check_val("rst_wstrb", {28'd0, ms_o_mem_wstrb}, 32'd0);
        check_val("rst_misaligned", {31'd0, ms_o_misaligned}, 32'd0);
        ms_rst = 1'b1;

        // ADD result write-back, latency 1, single-cycle pulse
        sb_q.push_back({5'd5, 32'h0000_1234});
        issue(op_add, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        after_access(1'b1);

        // No write for rd==0, we_reg==0, or flushed input
        issue(op_add, 3'b000, 32'h1111_1111, 32'h0, 5'd0, 1'b1);
        issue(op_add, 3'b000, 32'h2222_2222, 32'h0, 5'd3, 1'b0);
        ms_i_flush = 1'b1;
        issue(op_add, 3'b000, 32'h3333_3333, 32'h0, 5'd3, 1'b1);
        ms_i_flush = 1'b0;
        @(negedge ms_clk);
        check_val("flush_no_accept", {31'd0, ms_o_stall}, 32'd0);

        // LB at 0x103, ack two cycles after req
        sb_q.push_back({5'd7, 32'hFFFF_FF80});
        issue(op_load, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
        serve(2, 32'h80AA_BBCC, -1);
        check_val("lb_addr", cap_addr, 32'h0000_0100);
        check_val("lb_mem_we", {31'd0, cap_we}, 32'd0);
        check_val("lb_stall_cycles", stall_cycles, 32'd3);
        check_val("lb_req_cycles", req_cycles, 32'd3);
        check_val("lb_stable", {31'd0, stable_ok}, 32'd1);
        after_access(1'b1);

        // SH at 0x202
        issue(op_store, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd9, 1'b0);
        serve(1, 32'h0, -1);
        check_val("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        check_val("sh_wstrb", {28'd0, cap_wstrb}, 32'h0000_000C);
        check_val("sh_mem_we", {31'd0, cap_we}, 32'd1);
        check_val("sh_addr", cap_addr, 32'h0000_0200);
        after_access(1'b0);

        // LW rd=0 with ack in the first access cycle
        issue(op_load, 3'b010, 32'h0000_0400, 32'h0, 5'd0, 1'b1);
        serve(0, 32'h1234_5678, -1);
        check_val("lw0_req_cycles", req_cycles, 32'd1);
        check_val("lw0_stall_cycles", stall_cycles, 32'd1);
        after_access(1'b0);

        // LHU with flush before ack: transfer completes, no write-back
        issue(op_load, 3'b101, 32'h0000_0106, 32'h0, 5'd11, 1'b1);
        serve(3, 32'hABCD_0000, 1);
        check_val("flush_req_cycles", req_cycles, 32'd4);
        after_access(1'b0);

        // Reset during an access drops req immediately
        issue(op_load, 3'b010, 32'h0000_0300, 32'h0, 5'd4, 1'b1);
        @(negedge ms_clk);
        check_val("mid_req_before", {31'd0, ms_o_mem_req}, 32'd1);
        ms_rst = 1'b0;
        #1;
        check_val("mid_req_async", {31'd0, ms_o_mem_req}, 32'd0);
        check_val("mid_stall_async", {31'd0, ms_o_stall}, 32'd0);
        @(negedge ms_clk);
        ms_rst = 1'b1;
        @(negedge ms_clk);
        check_val("mid_idle", {31'd0, ms_o_stall}, 32'd0);

        // LW at 0x101
`ifdef MISALIGN_CHECK_EN
        issue(op_load, 3'b010, 32'h0000_0101, 32'h0, 5'd6, 1'b1);
        @(negedge ms_clk);
        check_val("mis_flag", {31'd0, ms_o_misaligned}, 32'd1);
        check_val("mis_req", {31'd0, ms_o_mem_req}, 32'd0);
        check_val("mis_stall", {31'd0, ms_o_stall}, 32'd0);
        @(negedge ms_clk);
        check_val("mis_flag_drop", {31'd0, ms_o_misaligned}, 32'd0);
`else
        sb_q.push_back({5'd6, 32'hCAFE_F00D});
        issue(op_load, 3'b010, 32'h0000_0101, 32'h0, 5'd6, 1'b1);
        serve(1, 32'hCAFE_F00D, -1);
        check_val("mis_addr", cap_addr, 32'h0000_0100);
        check_val("mis_flag_off", {31'd0, ms_o_misaligned}, 32'd0);
        after_access(1'b1);
`endif

        // Aligned load sweep against the extraction model
        for (int i = 0; i < 14; i++) begin
            rnd = $urandom;
            case (i % 5)
                0: f3 = 3'b000;
                1: f3 = 3'b100;
                2: f3 = 3'b001;
                3: f3 = 3'b101;
                default: f3 = 3'b010;
            endcase
            ln = 2'(i % 4);
            if (f3[1:0] == 2'b01) ln[0] = 1'b0;
            if (f3[1:0] == 2'b10) ln = 2'b00;
            sb_q.push_back({5'(1 + i), model_load(f3, ln, rnd)});
            issue(op_load, f3, {28'h0000_A00, 2'b00, ln} + 32'(i * 16), 32'h0, 5'(1 + i), 1'b1);
            serve(i % 3, rnd, -1);
            check_val("ld_addr", cap_addr, 32'h0000_A000 + 32'(i * 16));
        end

        // Store byte lanes and word
        for (int i = 0; i < 5; i++) begin
            rnd = $urandom;
            ln = 2'(i);
            issue(op_store, (i < 4) ? 3'b000 : 3'b010, {30'h0000_0040, (i < 4) ? ln : 2'b00},
                  rnd, 5'd2, 1'b0);
            serve(1, 32'h0, -1);
            check_val("st_wdata", cap_wdata, (i < 4) ? {4{rnd[7:0]}} : rnd);
            check_val("st_wstrb", {28'd0, cap_wstrb},
                      (i < 4) ? (32'd1 << i) : 32'h0000_000F);
        end

        repeat (2) @(negedge ms_clk);
        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
